// File: rtl/round_pkg.sv
// -----------------------------------------------------------------------------
// round_pkg
// Types and constants shared by the round sequencer files:
//   - state_t              : sequencer FSM state encoding
//   - DEFAULT_WORD_WIDTH   : default width of one normal word
//   - RES_SLOT_*           : word slot of each round_block result inside
//                            res_data (slot 3 is the most significant word)
// -----------------------------------------------------------------------------
package round_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_EMIT,
        S_FINISH
    } state_t;

    // res_data = {high_left, high_right, low_left, low_right}
    localparam int RES_SLOT_HIGH_LEFT  = 3;
    localparam int RES_SLOT_HIGH_RIGHT = 2;
    localparam int RES_SLOT_LOW_LEFT   = 1;
    localparam int RES_SLOT_LOW_RIGHT  = 0;

endpackage

// File: rtl/rs_watchdog.sv
// -----------------------------------------------------------------------------
// rs_watchdog
// Cycle counter guarding the sequencer's wait states. A load restarts the
// count at 1, so the count equals the number of cycles spent in the guarded
// state including the current one. expire is high while enabled and the
// count has reached LIMIT; the counter saturates there.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count (state entry)
//   enable     : guarded state is active; count advances
//   expire     : limit reached while enabled
// -----------------------------------------------------------------------------
module rs_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    // NOTE: flops are written with non-blocking (<=) so every register in the
    // design samples pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(1);
        end else if (enable && (count_q != CW'(LIMIT))) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expire = enable && (count_q == CW'(LIMIT));

endmodule

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
// Runs one round: reads num_words words from a word memory, hands each one to
// round_block, and streams out the four result words produced for every word
// except index 0 (which only primes round_block with only_add set).
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start, num_words, sparse_diff,
//   high_lat, low_lat               : round request and its configuration
//   busy, done, error               : round status (error is a sticky timeout)
//   mem_rd_en, mem_rd_addr,
//   mem_rd_data                     : word-memory read port (1-cycle latency)
//   rb_word_in, rb_word_valid,
//   rb_only_add, rb_sparse_diff,
//   rb_high_latency, rb_low_latency : word and controls towards round_block
//   rb_word_accepted,
//   rb_processing_done, rb_ready    : round_block status
//   rb_high_left .. rb_low_right    : round_block results
//   res_valid, res_ready, res_data,
//   res_index                       : result stream (valid/ready)
// -----------------------------------------------------------------------------
module round_sequencer
    import round_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     num_words,
    input  logic [5:0]              sparse_diff,
    input  logic                    high_lat,
    input  logic                    low_lat,

    output logic                    busy,
    output logic                    done,
    output logic                    error,

    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [WORD_WIDTH-1:0]   mem_rd_data,

    output logic [WORD_WIDTH-1:0]   rb_word_in,
    output logic                    rb_word_valid,
    output logic                    rb_only_add,
    output logic [5:0]              rb_sparse_diff,
    output logic                    rb_high_latency,
    output logic                    rb_low_latency,
    input  logic                    rb_word_accepted,
    input  logic                    rb_processing_done,
    input  logic                    rb_ready,
    input  logic [WORD_WIDTH-1:0]   rb_high_left,
    input  logic [WORD_WIDTH-1:0]   rb_high_right,
    input  logic [WORD_WIDTH-1:0]   rb_low_left,
    input  logic [WORD_WIDTH-1:0]   rb_low_right,

    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*WORD_WIDTH-1:0] res_data,
    output logic [ADDR_WIDTH-1:0]   res_index
);

    // Index is one bit wider than the address so a full 2^ADDR_WIDTH-word
    // round can compare against num_words without wrapping.
    localparam int IW = ADDR_WIDTH + 1;

    state_t                  state_q, state_d;

    logic [IW-1:0]           num_words_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_inc;
    logic [5:0]              sparse_q;
    logic                    high_lat_q;
    logic                    low_lat_q;
    logic [WORD_WIDTH-1:0]   word_q;
    logic [4*WORD_WIDTH-1:0] res_data_q;
    logic [ADDR_WIDTH-1:0]   res_index_q;
    logic                    error_q;

    logic                    start_ok;
    logic                    last_idx;
    logic                    idx_advance;
    logic                    capture_res;
    logic                    wd_load;
    logic                    wd_enable;
    logic                    wd_expire;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign idx_inc   = idx_q + IW'(1);
    assign last_idx  = (idx_inc == num_words_q);
    assign wd_enable = (state_q == S_WAIT_ACC) || (state_q == S_WAIT_DONE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_advance = 1'b0;
        capture_res = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? S_FINISH : S_FETCH;
                end
            end

            S_FETCH:   state_d = S_WAIT_RD;

            S_WAIT_RD: state_d = S_ISSUE;

            S_ISSUE: begin
                if (rb_ready) begin
                    state_d = S_WAIT_ACC;
                end
            end

            S_WAIT_ACC: begin
                if (wd_expire) begin
                    state_d = S_FINISH;
                end else if (rb_word_accepted) begin
                    if (idx_q == '0) begin
                        // Word 0 only primes round_block; nothing to collect.
                        idx_advance = 1'b1;
                        state_d     = last_idx ? S_FINISH : S_FETCH;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end

            S_WAIT_DONE: begin
                if (wd_expire) begin
                    state_d = S_FINISH;
                end else if (rb_processing_done) begin
                    capture_res = 1'b1;
                    state_d     = S_EMIT;
                end
            end

            S_EMIT: begin
                // The next read waits for the result handshake.
                if (res_ready) begin
                    idx_advance = 1'b1;
                    state_d     = last_idx ? S_FINISH : S_FETCH;
                end
            end

            S_FINISH:  state_d = S_IDLE;

            default:   state_d = S_IDLE;
        endcase
    end

    // Restart the watchdog on every entry into a guarded wait state.
    assign wd_load = (state_d != state_q) &&
                     ((state_d == S_WAIT_ACC) || (state_d == S_WAIT_DONE));

    rs_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (wd_load),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and latched configuration
    // -------------------------------------------------------------------------
    // NOTE: data and configuration registers are reset as well, so every
    // output reads zero during reset rather than a stale value from the
    // abandoned round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_words_q <= '0;
            idx_q       <= '0;
            sparse_q    <= '0;
            high_lat_q  <= 1'b0;
            low_lat_q   <= 1'b0;
            word_q      <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
            error_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                num_words_q <= num_words;
                sparse_q    <= sparse_diff;
                high_lat_q  <= high_lat;
                low_lat_q   <= low_lat;
                idx_q       <= '0;
                error_q     <= 1'b0;
            end else if (idx_advance) begin
                idx_q <= idx_inc;
            end

            // Read data is valid exactly one cycle after the request.
            if (state_q == S_WAIT_RD) begin
                word_q <= mem_rd_data;
            end

            if (capture_res) begin
                res_data_q[RES_SLOT_HIGH_LEFT*WORD_WIDTH  +: WORD_WIDTH] <= rb_high_left;
                res_data_q[RES_SLOT_HIGH_RIGHT*WORD_WIDTH +: WORD_WIDTH] <= rb_high_right;
                res_data_q[RES_SLOT_LOW_LEFT*WORD_WIDTH   +: WORD_WIDTH] <= rb_low_left;
                res_data_q[RES_SLOT_LOW_RIGHT*WORD_WIDTH  +: WORD_WIDTH] <= rb_low_right;
                res_index_q <= idx_q[ADDR_WIDTH-1:0];
            end

            if (wd_expire) begin
                error_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // busy is already low in FINISH so it falls together with the done pulse.
    assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done            = (state_q == S_FINISH);
    assign error           = error_q;

    assign mem_rd_en       = (state_q == S_FETCH);
    assign mem_rd_addr     = idx_q[ADDR_WIDTH-1:0];

    assign rb_word_in      = word_q;
    assign rb_word_valid   = (state_q == S_WAIT_ACC);
    assign rb_only_add     = busy && (idx_q == '0);
    assign rb_sparse_diff  = sparse_q;
    assign rb_high_latency = high_lat_q;
    assign rb_low_latency  = low_lat_q;

    assign res_valid       = (state_q == S_EMIT);
    assign res_data        = res_data_q;
    assign res_index       = res_index_q;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
// Bench for round_sequencer with a word-memory model, a round_block model and
// a scoreboard of expected reads, issued words and results.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam int WW = 32;
    localparam int AW = 6;
    localparam int TO = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW:0]       num_words = '0;
    logic [5:0]        sparse_diff = '0;
    logic              high_lat = 1'b0;
    logic              low_lat = 1'b0;
    logic              busy, done, error;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [WW-1:0]     mem_rd_data = '0;
    logic [WW-1:0]     rb_word_in;
    logic              rb_word_valid, rb_only_add;
    logic [5:0]        rb_sparse_diff;
    logic              rb_high_latency, rb_low_latency;
    logic              rb_word_accepted, rb_processing_done;
    logic              rb_ready = 1'b1;
    logic [WW-1:0]     rb_high_left, rb_high_right, rb_low_left, rb_low_right;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [4*WW-1:0]   res_data;
    logic [AW-1:0]     res_index;

    round_sequencer #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .num_words          (num_words),
        .sparse_diff        (sparse_diff),
        .high_lat           (high_lat),
        .low_lat            (low_lat),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_data        (mem_rd_data),
        .rb_word_in         (rb_word_in),
        .rb_word_valid      (rb_word_valid),
        .rb_only_add        (rb_only_add),
        .rb_sparse_diff     (rb_sparse_diff),
        .rb_high_latency    (rb_high_latency),
        .rb_low_latency     (rb_low_latency),
        .rb_word_accepted   (rb_word_accepted),
        .rb_processing_done (rb_processing_done),
        .rb_ready           (rb_ready),
        .rb_high_left       (rb_high_left),
        .rb_high_right      (rb_high_right),
        .rb_low_left        (rb_low_left),
        .rb_low_right       (rb_low_right),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .res_index          (res_index)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ models
    function automatic logic [WW-1:0] mem_word(input int a);
        logic [15:0] lo;
        lo = 16'h3C00 ^ 16'(a * 389);
        return {8'hA5, a[7:0], lo};
    endfunction

    function automatic logic [4*WW-1:0] rb_res(input logic [WW-1:0] w);
        return {w ^ 32'h1111_1111, w + 32'd1, ~w, {w[15:0], w[31:16]}};
    endfunction

    // Word memory: data one cycle after the request, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(int'(mem_rd_addr));
        else           mem_rd_data <= 32'hDEAD_BEEF;
    end

    // round_block: accepts a valid word one cycle after seeing it, and for
    // non-only_add words pulses processing_done 4 cycles after acceptance.
    bit          acc_en  = 1'b1;
    bit          done_en = 1'b1;
    logic        m_busy;
    int          m_cnt;
    logic [WW-1:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_word_accepted   <= 1'b0;
            rb_processing_done <= 1'b0;
            m_busy             <= 1'b0;
            m_cnt              <= 0;
            m_word             <= '0;
            rb_high_left       <= '0;
            rb_high_right      <= '0;
            rb_low_left        <= '0;
            rb_low_right       <= '0;
        end else begin
            rb_word_accepted   <= 1'b0;
            rb_processing_done <= 1'b0;
            if (rb_word_valid && !rb_word_accepted && !m_busy && acc_en)
                rb_word_accepted <= 1'b1;
            if (rb_word_valid && rb_word_accepted && !rb_only_add) begin
                m_busy <= 1'b1;
                m_cnt  <= 4;
                m_word <= rb_word_in;
            end
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    if (done_en) begin
                        rb_processing_done <= 1'b1;
                        {rb_high_left, rb_high_right, rb_low_left, rb_low_right} <= rb_res(m_word);
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // -------------------------------------------------------------- scoreboard
    typedef struct { logic [WW-1:0] w; logic only_add; } word_exp_t;
    typedef struct { logic [4*WW-1:0] data; logic [AW-1:0] idx; } res_exp_t;

    int        exp_addr_q[$];
    word_exp_t exp_word_q[$];
    res_exp_t  exp_res_q[$];
    logic [5:0] exp_sd = '0;
    logic       exp_hl = 1'b0;
    logic       exp_ll = 1'b0;
    int         rd_cnt = 0, res_cnt = 0, done_cnt = 0;

    int        mon_a;
    word_exp_t mon_w;
    res_exp_t  mon_r;

    // Handshakes are evaluated on the falling edge, i.e. with the values that
    // the next rising edge will sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    mon_a = exp_addr_q.pop_front();
                    check("rd_addr", mem_rd_addr, mon_a);
                end
            end
            if (rb_word_valid && rb_word_accepted) begin
                if (exp_word_q.size() == 0) check("word_unexpected", 1, 0);
                else begin
                    mon_w = exp_word_q.pop_front();
                    check("rb_word_in", rb_word_in, mon_w.w);
                    check("rb_only_add", rb_only_add, mon_w.only_add);
                    check("rb_sparse_diff", rb_sparse_diff, exp_sd);
                    check("rb_lat", {rb_high_latency, rb_low_latency}, {exp_hl, exp_ll});
                end
            end
            if (res_valid && res_ready) begin
                res_cnt++;
                if (exp_res_q.size() == 0) check("res_unexpected", 1, 0);
                else begin
                    mon_r = exp_res_q.pop_front();
                    check("res_data", res_data, mon_r.data);
                    check("res_index", res_index, mon_r.idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic pulse_start(input int n, input logic [5:0] sd, input logic hl,
                               input logic ll, input bit push);
        if (push) begin
            exp_sd  = sd;
            exp_hl  = hl;
            exp_ll  = ll;
            rd_cnt  = 0;
            res_cnt = 0;
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(i);
                exp_word_q.push_back('{mem_word(i), (i == 0)});
                if (i > 0) exp_res_q.push_back('{rb_res(mem_word(i)), AW'(i)});
            end
        end
        @(posedge clk); #1;
        num_words   = (AW+1)'(n);
        sparse_diff = sd;
        high_lat    = hl;
        low_lat     = ll;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic flush();
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_res_q.delete();
    endtask

    task automatic end_of_round(input int d0, input int reads, input int results);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("done_count", done_cnt - d0, 1);
        check("read_count", rd_cnt, reads);
        check("result_count", res_cnt, results);
        check("queues_empty", exp_addr_q.size() + exp_word_q.size() + exp_res_q.size(), 0);
    endtask

    typedef struct {
        int         n;
        logic [5:0] sd;
        logic       hl;
        logic       ll;
        int         exp_reads;
        int         exp_results;
    } vec_t;

    vec_t vecs[6];

    // ------------------------------------------------------------------- main
    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit   seen;
        int   cyc, d0;
        logic [4*WW-1:0] held_data;
        logic [AW-1:0]   held_idx;
        logic last_err;

        vecs[0] = '{3,  6'd6,  1'b1, 1'b0, 3,  2};
        vecs[1] = '{1,  6'd0,  1'b0, 1'b1, 1,  0};
        vecs[2] = '{0,  6'd63, 1'b1, 1'b1, 0,  0};
        vecs[3] = '{2,  6'd21, 1'b0, 1'b0, 2,  1};
        vecs[4] = '{64, 6'd5,  1'b1, 1'b1, 64, 63};
        vecs[5] = '{5,  6'd9,  1'b0, 1'b1, 5,  4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, error, mem_rd_en, rb_word_valid, rb_only_add, res_valid}, 7'b0);
        check("rst_data", {mem_rd_addr, rb_word_in, rb_sparse_diff, res_index}, '0);
        check("rst_res_data", res_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl", {busy, done, error, mem_rd_en, rb_word_valid, rb_only_add, res_valid}, 7'b0);

        // Table-driven rounds
        foreach (vecs[i]) begin
            d0 = done_cnt;
            pulse_start(vecs[i].n, vecs[i].sd, vecs[i].hl, vecs[i].ll, 1'b1);
            wait_done(3000, seen, cyc);
            check("done_seen", seen, 1);
            if (vecs[i].n == 0) check("zero_done_latency", cyc, 1);
            check("busy_at_done", busy, 0);
            check("error_at_done", error, 0);
            end_of_round(d0, vecs[i].exp_reads, vecs[i].exp_results);
        end

        // Result back-pressure: res_ready low for 10 cycles during EMIT
        res_ready = 1'b0;
        d0 = done_cnt;
        pulse_start(3, 6'd12, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        check("emit_reached", seen, 1);
        held_data = res_data;
        held_idx  = res_index;
        check("stall_index", held_idx, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", res_valid, 1);
            check("stall_data", {res_data, res_index}, {held_data, held_idx});
            check("stall_no_read", mem_rd_en, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done(500, seen, cyc);
        check("stall_done_seen", seen, 1);
        end_of_round(d0, 3, 2);

        // Config latched at start; a start while busy is ignored
        d0 = done_cnt;
        pulse_start(3, 6'd6, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        sparse_diff = 6'd9;
        num_words   = 7'd1;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        @(negedge clk);
        check("busy_after_ignored_start", busy, 1);
        check("sparse_held", rb_sparse_diff, 6);
        wait_done(500, seen, cyc);
        check("ign_done_seen", seen, 1);
        end_of_round(d0, 3, 2);
        repeat (3) @(negedge clk);
        check("no_extra_round", {busy, done}, 2'b00);

        // Watchdog in WAIT_DONE
        done_en = 1'b0;
        d0 = done_cnt;
        pulse_start(2, 6'd3, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rb_word_valid && rb_word_accepted && !rb_only_add;
        end
        check("wd_word1_accepted", seen, 1);
        last_err = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            last_err = error;
        end
        check("wd_done_cycle", cyc, TO + 1);
        check("wd_error_before", last_err, 0);
        check("wd_error_at_done", error, 1);
        check("wd_busy_at_done", busy, 0);
        @(negedge clk);
        check("wd_error_sticky", error, 1);
        check("wd_done_count", done_cnt - d0, 1);
        flush();
        done_en = 1'b1;

        // Watchdog in WAIT_ACC; the next start clears error
        acc_en = 1'b0;
        pulse_start(1, 6'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("wa_error_cleared", error, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = rb_word_valid;
            if (!seen) @(negedge clk);
        end
        check("wa_valid_seen", seen, 1);
        cyc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
        end
        check("wa_done_cycle", cyc, TO);
        check("wa_error", error, 1);
        check("wa_valid_dropped", rb_word_valid, 0);
        flush();
        acc_en = 1'b1;

        // Reset during WAIT_DONE, then a normal round
        pulse_start(3, 6'd17, 1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rb_word_valid && rb_word_accepted && !rb_only_add;
        end
        check("rst_word1_accepted", seen, 1);
        @(posedge clk); #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {busy, done, error, mem_rd_en, rb_word_valid, rb_only_add, res_valid}, 7'b0);
        check("midrst_cfg", {rb_sparse_diff, rb_high_latency, rb_low_latency, mem_rd_addr}, '0);
        check("midrst_data", {rb_word_in, res_index}, '0);
        @(negedge clk);
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        pulse_start(2, 6'd8, 1'b0, 1'b1, 1'b1);
        wait_done(500, seen, cyc);
        check("post_rst_done_seen", seen, 1);
        check("post_rst_error", error, 0);
        end_of_round(d0, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
